// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO shadow checker: err_vec bit positions,
// the err_vec type and the expected combinational flag decode.
package fifo_chk_pkg;

  localparam int ERR_DATA         = 0;
  localparam int ERR_WRITE_ACK    = 1;
  localparam int ERR_OVERFLOW     = 2;
  localparam int ERR_UNDERFLOW    = 3;
  localparam int ERR_FULL         = 4;
  localparam int ERR_EMPTY        = 5;
  localparam int ERR_ALMOST_FULL  = 6;
  localparam int ERR_ALMOST_EMPTY = 7;

  typedef logic [7:0] err_vec_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  // Flags a correct FIFO shows combinationally for a given fill level.
  function automatic flags_t calc_flags(input int unsigned count,
                                        input int unsigned depth);
    flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 0);
    f.almost_full  = (count == depth - 1);
    f.almost_empty = (count == 1);
    return f;
  endfunction

endpackage

// File: rtl/fifo_chk_model.sv
// Shadow FIFO: mirrors the observed FIFO's storage, fill level and the
// registered outputs a correct FIFO would present one cycle after a request.
// Acceptance is decided from the shadow's own count, never from DUT flags,
// so a faulty DUT cannot drag the reference along with it.
module fifo_chk_model #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      exp_write_ack,
  output logic                      exp_overflow,
  output logic                      exp_underflow,
  output logic [DATA_WIDTH-1:0]     exp_data_out,
  output logic                      exp_rd_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Full blocks writes and empty blocks reads, which also settles the
  // simultaneous cases (read wins when full, write wins when empty).
  assign wr_acc = wr_en && (count != CNT_W'(DEPTH));
  assign rd_acc = rd_en && (count != '0);

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, fill level and the expected registered DUT outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      exp_write_ack <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
      exp_data_out  <= '0;
      exp_rd_valid  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr       <= rd_ptr + 1'b1;
        exp_data_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      exp_write_ack <= wr_acc;
      exp_overflow  <= wr_en && !wr_acc;
      exp_underflow <= rd_en && !rd_acc;
      exp_rd_valid  <= rd_acc;
    end
  end

endmodule

// File: rtl/fifo_shadow_checker.sv
// In-line checker for a synchronous FIFO. Runs fifo_chk_model beside the
// observed FIFO, compares data and all seven flags every cycle, keeps
// saturating outcome counters and, when FIFO_CHK_FIRST_ERR_EN is defined,
// captures the first failing err_vec with its cycle index.
module fifo_shadow_checker
  import fifo_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_en,
  input  logic                  clr_cnt,
  input  logic                  obs_wr_en,
  input  logic                  obs_rd_en,
  input  logic [DATA_WIDTH-1:0] obs_data_in,
  input  logic [DATA_WIDTH-1:0] obs_data_out,
  input  logic                  obs_write_ack,
  input  logic                  obs_overflow,
  input  logic                  obs_underflow,
  input  logic                  obs_full,
  input  logic                  obs_empty,
  input  logic                  obs_almost_full,
  input  logic                  obs_almost_empty,
  output logic                  err_pulse,
  output logic [7:0]            err_vec,
  output logic [CNT_WIDTH-1:0]  corr_data_cnt,
  output logic [CNT_WIDTH-1:0]  err_data_cnt,
  output logic [CNT_WIDTH-1:0]  corr_flag_cnt,
  output logic [CNT_WIDTH-1:0]  err_flag_cnt,
  output logic                  first_err_valid,
  output logic [7:0]            first_err_vec,
  output logic [CNT_WIDTH-1:0]  first_err_cycle
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [$clog2(DEPTH):0] m_count;
  logic                   m_write_ack;
  logic                   m_overflow;
  logic                   m_underflow;
  logic [DATA_WIDTH-1:0]  m_data_out;
  logic                   m_rd_valid;
  flags_t                 exp_flags;
  err_vec_t               mism;
  err_vec_t               err_next;
  logic                   flag_err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  fifo_chk_model #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_model (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (obs_wr_en),
    .rd_en         (obs_rd_en),
    .data_in       (obs_data_in),
    .count         (m_count),
    .exp_write_ack (m_write_ack),
    .exp_overflow  (m_overflow),
    .exp_underflow (m_underflow),
    .exp_data_out  (m_data_out),
    .exp_rd_valid  (m_rd_valid)
  );

  assign exp_flags = calc_flags(32'(m_count), DEPTH);

  // Per-check mismatches against the model state before this edge; data is
  // only meaningful in the cycle after an accepted read.
  always_comb begin
    mism                   = '0;
    mism[ERR_DATA]         = m_rd_valid && (obs_data_out != m_data_out);
    mism[ERR_WRITE_ACK]    = obs_write_ack    != m_write_ack;
    mism[ERR_OVERFLOW]     = obs_overflow     != m_overflow;
    mism[ERR_UNDERFLOW]    = obs_underflow    != m_underflow;
    mism[ERR_FULL]         = obs_full         != exp_flags.full;
    mism[ERR_EMPTY]        = obs_empty        != exp_flags.empty;
    mism[ERR_ALMOST_FULL]  = obs_almost_full  != exp_flags.almost_full;
    mism[ERR_ALMOST_EMPTY] = obs_almost_empty != exp_flags.almost_empty;
  end

  assign err_next = chk_en ? mism : '0;
  assign flag_err = |mism[ERR_ALMOST_EMPTY:ERR_WRITE_ACK];

  // Registered failure report, valid the cycle after the compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_vec   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_vec   <= err_next;
      err_pulse <= |err_next;
    end
  end

  // Outcome counters; clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      corr_data_cnt <= '0;
      err_data_cnt  <= '0;
      corr_flag_cnt <= '0;
      err_flag_cnt  <= '0;
    end else if (chk_en) begin
      if (m_rd_valid) begin
        if (mism[ERR_DATA]) begin
          err_data_cnt <= sat_inc(err_data_cnt);
        end else begin
          corr_data_cnt <= sat_inc(corr_data_cnt);
        end
      end
      if (flag_err) begin
        err_flag_cnt <= sat_inc(err_flag_cnt);
      end else begin
        corr_flag_cnt <= sat_inc(corr_flag_cnt);
      end
    end
  end

`ifdef FIFO_CHK_FIRST_ERR_EN
  logic [CNT_WIDTH-1:0] cycle_cnt;

  // Index of the current compare cycle since reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cycle_cnt <= '0;
    end else if (chk_en) begin
      cycle_cnt <= sat_inc(cycle_cnt);
    end
  end

  // Sticky capture of the first failing err_vec, loaded alongside err_vec.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
      first_err_cycle <= '0;
    end else if (!first_err_valid && (err_next != '0)) begin
      first_err_valid <= 1'b1;
      first_err_vec   <= err_next;
      first_err_cycle <= cycle_cnt;
    end
  end
`else
  assign first_err_valid = 1'b0;
  assign first_err_vec   = '0;
  assign first_err_cycle = '0;
`endif

endmodule

// File: tb/tb_fifo_shadow_checker.sv
// Bench for fifo_shadow_checker: a queue-based behavioural FIFO drives the
// observed signals, optional XOR masks corrupt them, and the expected
// checker outputs follow directly from which signals were corrupted.
module tb_fifo_shadow_checker;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
`ifdef FIFO_CHK_FIRST_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic          clk;
  logic          rst, chk_en, clr_cnt;
  logic          obs_wr_en, obs_rd_en;
  logic [DW-1:0] obs_data_in, obs_data_out;
  logic          obs_write_ack, obs_overflow, obs_underflow;
  logic          obs_full, obs_empty, obs_almost_full, obs_almost_empty;

  logic          err_pulse, err_pulse4;
  logic [7:0]    err_vec, err_vec4;
  logic [15:0]   corr_data_cnt, err_data_cnt, corr_flag_cnt, err_flag_cnt;
  logic [3:0]    corr_data_cnt4, err_data_cnt4, corr_flag_cnt4, err_flag_cnt4;
  logic          first_err_valid, first_err_valid4;
  logic [7:0]    first_err_vec, first_err_vec4;
  logic [15:0]   first_err_cycle;
  logic [3:0]    first_err_cycle4;

  fifo_shadow_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_cnt(clr_cnt),
    .obs_wr_en(obs_wr_en), .obs_rd_en(obs_rd_en),
    .obs_data_in(obs_data_in), .obs_data_out(obs_data_out),
    .obs_write_ack(obs_write_ack), .obs_overflow(obs_overflow),
    .obs_underflow(obs_underflow), .obs_full(obs_full), .obs_empty(obs_empty),
    .obs_almost_full(obs_almost_full), .obs_almost_empty(obs_almost_empty),
    .err_pulse(err_pulse), .err_vec(err_vec),
    .corr_data_cnt(corr_data_cnt), .err_data_cnt(err_data_cnt),
    .corr_flag_cnt(corr_flag_cnt), .err_flag_cnt(err_flag_cnt),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec),
    .first_err_cycle(first_err_cycle)
  );

  fifo_shadow_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_cnt(clr_cnt),
    .obs_wr_en(obs_wr_en), .obs_rd_en(obs_rd_en),
    .obs_data_in(obs_data_in), .obs_data_out(obs_data_out),
    .obs_write_ack(obs_write_ack), .obs_overflow(obs_overflow),
    .obs_underflow(obs_underflow), .obs_full(obs_full), .obs_empty(obs_empty),
    .obs_almost_full(obs_almost_full), .obs_almost_empty(obs_almost_empty),
    .err_pulse(err_pulse4), .err_vec(err_vec4),
    .corr_data_cnt(corr_data_cnt4), .err_data_cnt(err_data_cnt4),
    .corr_flag_cnt(corr_flag_cnt4), .err_flag_cnt(err_flag_cnt4),
    .first_err_valid(first_err_valid4), .first_err_vec(first_err_vec4),
    .first_err_cycle(first_err_cycle4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [15:0] din;
    logic [7:0] inj;
    bit         en;
    bit         clr;
    logic [7:0] exp_err;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural FIFO state (what a correct DUT would present).
  logic [15:0] q[$];
  bit          b_ack, b_ovf, b_udf, b_rdv;
  logic [15:0] b_dout;

  // Expected checker state.
  logic [7:0]  e_err;
  int          e_cd, e_ed, e_cf, e_ef, e_cyc, e_fecyc;
  bit          e_fev;
  logic [7:0]  e_fevec;

  function automatic int inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    e_cd = 0; e_ed = 0; e_cf = 0; e_ef = 0; e_cyc = 0;
    e_fev = 0; e_fevec = '0; e_fecyc = 0;
  endtask

  task automatic step(input bit wr, input bit rd, input logic [15:0] din,
                      input logic [7:0] inj, input bit en, input bit clr,
                      input bit rs);
    logic [7:0] m;
    bit wa, ra;
    int sz;
    @(negedge clk);
    sz = q.size();
    rst              = rs;
    chk_en           = en;
    clr_cnt          = clr;
    obs_wr_en        = wr;
    obs_rd_en        = rd;
    obs_data_in      = din;
    obs_data_out     = inj[0] ? ~b_dout : b_dout;
    obs_write_ack    = b_ack ^ inj[1];
    obs_overflow     = b_ovf ^ inj[2];
    obs_underflow    = b_udf ^ inj[3];
    obs_full         = (sz == DEPTH) ^ inj[4];
    obs_empty        = (sz == 0) ^ inj[5];
    obs_almost_full  = (sz == DEPTH - 1) ^ inj[6];
    obs_almost_empty = (sz == 1) ^ inj[7];
    m = inj;
    if (!b_rdv) m[0] = 1'b0;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      b_ack = 0; b_ovf = 0; b_udf = 0; b_rdv = 0; b_dout = '0;
      e_err = '0;
      clear_model();
    end else begin
      e_err = en ? m : 8'h00;
      if (clr) begin
        clear_model();
      end else if (en) begin
        if (b_rdv) begin
          if (m[0]) e_ed = inc(e_ed); else e_cd = inc(e_cd);
        end
        if (m[7:1] != 7'd0) e_ef = inc(e_ef); else e_cf = inc(e_cf);
        if (!e_fev && m != 8'h00) begin
          e_fev = 1; e_fevec = m; e_fecyc = e_cyc;
        end
        e_cyc = inc(e_cyc);
      end
      wa = wr && (sz < DEPTH);
      ra = rd && (sz > 0);
      if (ra) b_dout = q.pop_front();
      if (wa) q.push_back(din);
      b_ack = wa;
      b_ovf = wr && !wa;
      b_udf = rd && !ra;
      b_rdv = ra;
    end
    chk("err_vec",         int'(err_vec),        int'(e_err));
    chk("err_pulse",       int'(err_pulse),      int'(e_err != 8'h00));
    chk("corr_data_cnt",   int'(corr_data_cnt),  e_cd);
    chk("err_data_cnt",    int'(err_data_cnt),   e_ed);
    chk("corr_flag_cnt",   int'(corr_flag_cnt),  e_cf);
    chk("err_flag_cnt",    int'(err_flag_cnt),   e_ef);
    chk("err_vec_w4",      int'(err_vec4),       int'(e_err));
    chk("corr_data_cnt_w4", int'(corr_data_cnt4), sat4(e_cd));
    chk("err_data_cnt_w4", int'(err_data_cnt4),  sat4(e_ed));
    chk("corr_flag_cnt_w4", int'(corr_flag_cnt4), sat4(e_cf));
    chk("err_flag_cnt_w4", int'(err_flag_cnt4),  sat4(e_ef));
    chk("first_err_valid", int'(first_err_valid), FE_EN ? int'(e_fev) : 0);
    chk("first_err_vec",   int'(first_err_vec),   FE_EN ? int'(e_fevec) : 0);
    chk("first_err_cycle", int'(first_err_cycle), FE_EN ? e_fecyc : 0);
    chk("first_err_cycle_w4", int'(first_err_cycle4), FE_EN ? sat4(e_fecyc) : 0);
  endtask

  task automatic add(inout vec_t t[$], input bit wr, input bit rd,
                     input logic [15:0] din, input logic [7:0] inj,
                     input bit en, input bit clr, input logic [7:0] exp_err);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.inj = inj;
    v.en = en; v.clr = clr; v.exp_err = exp_err;
    t.push_back(v);
  endtask

  initial begin
    rst = 1; chk_en = 0; clr_cnt = 0; obs_wr_en = 0; obs_rd_en = 0;
    obs_data_in = '0; obs_data_out = '0; obs_write_ack = 0; obs_overflow = 0;
    obs_underflow = 0; obs_full = 0; obs_empty = 1; obs_almost_full = 0;
    obs_almost_empty = 0;
    b_ack = 0; b_ovf = 0; b_udf = 0; b_rdv = 0; b_dout = '0; e_err = '0;
    clear_model();

    // Fill, overflow, clear, drain with one corrupted read, underflow.
    for (int i = 1; i <= 8; i++) add(tbl1, 1, 0, 16'(i), 8'h00, 1, 0, 8'h00);
    add(tbl1, 1, 0, 16'h0099, 8'h00, 1, 0, 8'h00);
    add(tbl1, 0, 0, 16'h0000, 8'h04, 1, 0, 8'h04);
    add(tbl1, 0, 0, 16'h0000, 8'h00, 1, 1, 8'h00);
    for (int i = 1; i <= 8; i++)
      add(tbl1, 0, 1, 16'h0000, (i == 4) ? 8'h01 : 8'h00, 1, 0,
          (i == 4) ? 8'h01 : 8'h00);
    add(tbl1, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00);
    add(tbl1, 0, 1, 16'h0000, 8'h00, 1, 0, 8'h00);
    add(tbl1, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00);
    add(tbl1, 0, 0, 16'h0000, 8'h01, 1, 0, 8'h00);
    add(tbl1, 1, 1, 16'h00A5, 8'h00, 1, 0, 8'h00);
    add(tbl1, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00);

    // Steady count of 4 with simultaneous rd/wr across pointer wrap.
    add(tbl2, 0, 1, 16'h0000, 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(tbl2, 1, 0, 16'(16'h0010 + i), 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < 20; i++) add(tbl2, 1, 1, 16'(16'h0020 + i), 8'h00, 1, 0, 8'h00);
    add(tbl2, 0, 0, 16'h0000, 8'h30, 1, 0, 8'h30);
    add(tbl2, 0, 0, 16'h0000, 8'hC0, 1, 0, 8'hC0);
    add(tbl2, 0, 0, 16'h0000, 8'h02, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(tbl2, 0, 1, 16'h0000, 8'h00, 1, 0, 8'h00);
    add(tbl2, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h00);

    step(0, 0, 16'h0, 8'h00, 0, 0, 1);
    step(0, 0, 16'h0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 8'h00, 1, 0, 0);
    chk("idle_corr_flag", int'(corr_flag_cnt), 3);
    chk("idle_err_flag",  int'(err_flag_cnt), 0);
    chk("idle_err_data",  int'(err_data_cnt), 0);

    foreach (tbl1[i]) begin
      step(tbl1[i].wr, tbl1[i].rd, tbl1[i].din, tbl1[i].inj, tbl1[i].en,
           tbl1[i].clr, 0);
      chk($sformatf("tbl1_err_vec[%0d]", i), int'(err_vec), int'(tbl1[i].exp_err));
    end
    chk("drain_corr_data", int'(corr_data_cnt), 7);
    chk("drain_err_data",  int'(err_data_cnt), 1);
    chk("drain_corr_flag", int'(corr_flag_cnt), 14);
    chk("drain_err_flag",  int'(err_flag_cnt), 0);
    chk("drain_first_vec", int'(first_err_vec), FE_EN ? 1 : 0);
    chk("drain_first_cyc", int'(first_err_cycle), FE_EN ? 3 : 0);

    foreach (tbl2[i]) begin
      step(tbl2[i].wr, tbl2[i].rd, tbl2[i].din, tbl2[i].inj, tbl2[i].en,
           tbl2[i].clr, 0);
      chk($sformatf("tbl2_err_vec[%0d]", i), int'(err_vec), int'(tbl2[i].exp_err));
    end

    // Saturation of the narrow instance, clear, and disabled counting.
    step(0, 0, 16'h0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 16'h0, 8'h00, 1, 0, 0);
    chk("sat_corr_flag_w4", int'(corr_flag_cnt4), 15);
    chk("sat_corr_flag",    int'(corr_flag_cnt), 20);
    step(0, 0, 16'h0, 8'h00, 1, 1, 0);
    chk("clr_corr_flag_w4", int'(corr_flag_cnt4), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 8'hFF, 0, 0, 0);
    chk("dis_corr_flag", int'(corr_flag_cnt), 0);
    chk("dis_err_flag",  int'(err_flag_cnt), 0);
    chk("dis_err_vec",   int'(err_vec), 0);

    // Randomized traffic with faults, clears, disables and resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 16'($urandom),
           ($urandom_range(9) == 0) ? 8'($urandom) : 8'h00,
           $urandom_range(9) != 0, $urandom_range(49) == 0,
           $urandom_range(99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
